// File: rtl/ddr_port0_arbiter.sv
// Arbiter for DDR port 0: sequences one MCB command at a time between the render
// writer and the display-fetch reader, gated on calibration and FIFO status.
module ddr_port0_arbiter #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        wr_req,
    input  logic [29:0] wr_addr,
    input  logic [5:0]  wr_bl,
    output logic        wr_grant,
    output logic        wr_done,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    input  logic [5:0]  rd_bl,
    output logic        rd_grant,
    output logic        rd_done,
    input  logic        rd_urgent,
    input  logic        p0_cmd_full,
    input  logic [6:0]  p0_wr_count,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        CALIB = 3'd0,
        IDLE  = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0]  STARVE_LIM8 = 8'(STARVE_LIMIT);
    localparam logic [29:0] ADDR_MASK   = ~30'h3;

    state_t      state;
    state_t      state_next;
    logic        calib_meta;
    logic        calib_sync;
    logic        grant_q;
    logic        sel_rd;
    logic        last_rd;
    logic [29:0] lat_addr;
    logic [5:0]  lat_bl;
    logic [7:0]  starve_cnt;
    logic        pick_valid;
    logic        pick_rd;
    logic        take;
    logic        wait_ok;
    logic        write_busy;

    // Two-flop synchroniser for the asynchronous calibration flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= mem_calib_done;
            calib_sync <= calib_meta;
        end
    end

    // Winner selection: urgent read, starved write, sole requester, round-robin
    always_comb begin
        pick_valid = 1'b0;
        pick_rd    = 1'b0;
        if (rd_urgent && rd_req) begin
            pick_valid = 1'b1;
            pick_rd    = 1'b1;
        end else if (wr_req && (starve_cnt >= STARVE_LIM8)) begin
            pick_valid = 1'b1;
            pick_rd    = 1'b0;
        end else if (wr_req && !rd_req) begin
            pick_valid = 1'b1;
            pick_rd    = 1'b0;
        end else if (rd_req && !wr_req) begin
            pick_valid = 1'b1;
            pick_rd    = 1'b1;
        end else if (wr_req && rd_req) begin
            pick_valid = 1'b1;
            pick_rd    = !last_rd;
        end
    end

    assign take       = (state == IDLE) && calib_sync && pick_valid;
    assign write_busy = ((state == WAIT) || (state == ISSUE) || (state == DONE)) && !sel_rd;
    assign wait_ok    = !p0_cmd_full &&
                        (sel_rd || (p0_wr_count >= ({1'b0, lat_bl} + 7'd1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CALIB;
        end else begin
            state <= state_next;
        end
    end

    // Calibration loss aborts IDLE/WAIT at once but lets ISSUE/DONE run out
    always_comb begin
        state_next = state;
        case (state)
            CALIB: if (calib_sync) state_next = IDLE;
            IDLE: begin
                if (!calib_sync)     state_next = CALIB;
                else if (pick_valid) state_next = WAIT;
            end
            WAIT: begin
                if (!calib_sync)  state_next = CALIB;
                else if (wait_ok) state_next = ISSUE;
            end
            ISSUE:   state_next = DONE;
            DONE:    state_next = calib_sync ? IDLE : CALIB;
            default: state_next = CALIB;
        endcase
    end

    always_comb begin
        wr_grant  = grant_q && !sel_rd;
        rd_grant  = grant_q && sel_rd;
        p0_cmd_en = (state == ISSUE);
        wr_done   = (state == DONE) && !sel_rd;
        rd_done   = (state == DONE) && sel_rd;
        state_dbg = state;
    end

    assign p0_cmd_instr     = {2'b00, sel_rd};
    assign p0_cmd_bl        = lat_bl;
    assign p0_cmd_byte_addr = lat_addr;

    // Command latch, fairness history and write starvation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= 1'b0;
            sel_rd     <= 1'b0;
            last_rd    <= 1'b1;
            lat_addr   <= '0;
            lat_bl     <= '0;
            starve_cnt <= '0;
        end else begin
            grant_q <= take;
            if (take) begin
                sel_rd   <= pick_rd;
                lat_addr <= (pick_rd ? rd_addr : wr_addr) & ADDR_MASK;
                lat_bl   <= pick_rd ? rd_bl : wr_bl;
            end
            if (state == ISSUE) begin
                last_rd <= sel_rd;
            end
            if (take && !pick_rd) begin
                starve_cnt <= '0;
            end else if (wr_req && !write_busy && (starve_cnt != 8'hFF)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule
